// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus for prog_loader.
// slave  : the loader (consumes bytes, drives the memory write port)
// master : the byte source / memory side (drives bytes, observes writes)
interface prog_loader_if #(
  parameter int D = 10,
  parameter int W = 9
);
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         imem_wr_en;
  logic [D-1:0] imem_addr;
  logic [W-1:0] imem_wr_data;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_wr_en,
    output imem_addr,
    output imem_wr_data
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_wr_en,
    input  imem_addr,
    input  imem_wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time instruction loader: parses a byte stream (16-bit word count,
// then 9-bit words sent as two bytes each) into sequential instruction
// memory writes, holding the CPU in reset until the image is complete.
// Optional feature: define PROG_LOADER_CKSUM_EN to require a trailing
// XOR checksum byte covering every byte accepted in the session.
module prog_loader #(
  parameter int D = 10,
  parameter int W = 9
) (
  input  logic            clk,
  input  logic            reset,      // asynchronous, active low
  input  logic            start,
  prog_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            load_done,
  output logic            err
);

`ifdef PROG_LOADER_CKSUM_EN
  typedef enum logic [3:0] {
    IDLE, HDR_LO, HDR_HI, W_LO, W_HI, CKSUM, FLUSH, DONE, ERR
  } state_t;
  // State entered once the last word (or an empty header) is accepted.
  localparam state_t TAIL = CKSUM;
`else
  typedef enum logic [3:0] {
    IDLE, HDR_LO, HDR_HI, W_LO, W_HI, FLUSH, DONE, ERR
  } state_t;
  localparam state_t TAIL = FLUSH;
`endif

  state_t       state_reg, state_next;
  logic [D-1:0] idx_reg, idx_next;
  logic [D-1:0] count_reg, count_next;
  logic [7:0]   count_lo_reg, count_lo_next;
  logic [7:0]   lo_reg, lo_next;
  logic         wr_en_reg, wr_en_next;
  logic [D-1:0] addr_reg, addr_next;
  logic [W-1:0] data_reg, data_next;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]   ck_reg, ck_next;
`endif

  logic         ready;
  logic         xfer;
  logic [15:0]  hdr16;

  // Byte acceptance and status outputs decode directly from the state.
  always_comb begin
    ready = 1'b0;
    case (state_reg)
      HDR_LO, HDR_HI, W_LO, W_HI: ready = 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
      CKSUM:                      ready = 1'b1;
`endif
      default:                    ready = 1'b0;
    endcase
  end

  assign bus.in_ready     = ready;
  assign bus.imem_wr_en   = wr_en_reg;
  assign bus.imem_addr    = addr_reg;
  assign bus.imem_wr_data = data_reg;
  assign cpu_hold         = (state_reg != DONE);
  assign load_done        = (state_reg == DONE);
  assign err              = (state_reg == ERR);

  assign xfer  = bus.in_valid && ready;
  assign hdr16 = {bus.in_data, count_lo_reg};

  // Next-state logic: start overrides everything, including a byte in flight.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    count_next    = count_reg;
    count_lo_next = count_lo_reg;
    lo_next       = lo_reg;
    wr_en_next    = 1'b0;
    addr_next     = addr_reg;
    data_next     = data_reg;
`ifdef PROG_LOADER_CKSUM_EN
    ck_next       = ck_reg;
`endif
    if (start) begin
      state_next = HDR_LO;
      idx_next   = '0;
`ifdef PROG_LOADER_CKSUM_EN
      ck_next    = 8'h00;
`endif
    end else if (xfer) begin
`ifdef PROG_LOADER_CKSUM_EN
      ck_next = ck_reg ^ bus.in_data;
`endif
      case (state_reg)
        HDR_LO: begin
          count_lo_next = bus.in_data;
          state_next    = HDR_HI;
        end
        HDR_HI: begin
          // Counts that do not fit the address space are rejected outright.
          if ((hdr16 >> D) != 16'd0) begin
            state_next = ERR;
          end else begin
            count_next = hdr16[D-1:0];
            state_next = (hdr16[D-1:0] == '0) ? TAIL : W_LO;
          end
        end
        W_LO: begin
          lo_next    = bus.in_data;
          state_next = W_HI;
        end
        W_HI: begin
          if (bus.in_data[7:1] != 7'd0) begin
            state_next = ERR;
          end else begin
            wr_en_next = 1'b1;
            addr_next  = idx_reg;
            data_next  = {bus.in_data[0], lo_reg};
            idx_next   = idx_reg + 1'b1;
            state_next = (idx_reg == count_reg - 1'b1) ? TAIL : W_LO;
          end
        end
`ifdef PROG_LOADER_CKSUM_EN
        CKSUM: begin
          state_next = (bus.in_data == ck_reg) ? FLUSH : ERR;
        end
`endif
        default: state_next = state_reg;
      endcase
    end else if (state_reg == FLUSH) begin
      state_next = DONE;
    end
  end

  // State and datapath registers; reset aborts any session immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      count_reg    <= '0;
      count_lo_reg <= 8'h00;
      lo_reg       <= 8'h00;
      wr_en_reg    <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      ck_reg       <= 8'h00;
`endif
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      count_reg    <= count_next;
      count_lo_reg <= count_lo_next;
      lo_reg       <= lo_next;
      wr_en_reg    <= wr_en_next;
      addr_reg     <= addr_next;
      data_reg     <= data_next;
`ifdef PROG_LOADER_CKSUM_EN
      ck_reg       <= ck_next;
`endif
    end
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time instruction loader that sits directly upstream of the processor's instruction memory. It accepts a byte stream carrying a word count followed by 9-bit machine-code words and writes each word into instruction memory at sequential addresses. It holds the CPU in reset until the image is fully written, then releases the CPU and flags completion. A malformed stream leaves the CPU held and raises an error.

## Interface
Parameters:
- `D`, 10: instruction address width, matching the program counter width; legal range 9..16.
- `W`, 9: machine-code word width; fixed at 9.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  one-cycle pulse that begins or restarts a load session.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte.
- `in_ready`  out  1  loader can accept a byte; a byte transfers when `in_valid & in_ready`.
- `imem_wr_en`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  D  write address (word index).
- `imem_wr_data`  out  W  machine-code word.
- `cpu_hold`  out  1  1 = keep the CPU in reset.
- `load_done`  out  1  image loaded; the CPU is released.
- `err`  out  1  malformed stream detected.

## Operation
- States: IDLE, HDR_LO, HDR_HI, W_LO, W_HI, CKSUM (macro only), FLUSH, DONE, ERR.
- `start` in any state: go to HDR_LO, clear the word index, clear `err` and `load_done`, and set `cpu_hold` = 1. `start` takes priority over a byte transfer in the same cycle; that byte is dropped.
- `in_ready` = 1 in HDR_LO, HDR_HI, W_LO, W_HI and CKSUM. It is 0 in all other states.
- Header: HDR_LO byte is count[7:0]. HDR_HI byte is count[15:8].
  - The count uses bits [D-1:0] only.
  - Any set bit at position D..15 → ERR.
- Count = 0: after HDR_HI, go to CKSUM if the macro is defined, else FLUSH. No writes occur.
- Word format:
  - W_LO byte is word[7:0].
  - W_HI byte bit0 is word[8].
  - W_HI bits[7:1] nonzero → ERR, and that word is not written.
- Accepting a valid W_HI byte:
  - Registers `imem_wr_data` and `imem_addr` = word index, and pulses `imem_wr_en` the next cycle.
  - Increments the word index.
  - Goes to W_LO, or, after the last word, to CKSUM or FLUSH.
- FLUSH: one cycle, then DONE.
- DONE: `load_done` = 1 and `cpu_hold` = 0. Stays there until `start` or reset.
- ERR: `err` = 1 and `cpu_hold` = 1. Stays there until `start` or reset.
- The word index never wraps, because the count is at most 2^D − 1.

## Timing
- Reset values: `in_ready` 0, `imem_wr_en` 0, `imem_addr` 0, `imem_wr_data` 0, `cpu_hold` 1, `load_done` 0, `err` 0, state IDLE.
- Reset asserted mid-session aborts immediately to the reset values. Words already written remain in memory.
- Write latency: `imem_wr_en` is high exactly in the cycle after the W_HI byte transfers. Address and data are valid in that same cycle.
- Completion:
  - `load_done` rises and `cpu_hold` falls together, two cycles after the final byte transfers.
  - The final byte is the last W_HI byte, or the HDR_HI byte if count = 0, or the checksum byte when the macro is defined.
- Error: `err` rises one cycle after the offending byte transfers.
- Gaps in `in_valid` only stall the loader; no timeout.
- Throughput: one byte per cycle sustained.

## Configuration
- `PROG_LOADER_CKSUM_EN` defined:
  - After the last word (or after the header when count = 0), one extra byte is required.
  - That byte must equal the XOR of every byte accepted in the session, header included.
  - Mismatch → ERR. Match → FLUSH.
- `PROG_LOADER_CKSUM_EN` undefined: no CKSUM state; the stream ends after the last word.

## Test plan
- Basic load (macro off):
  - Stimulus: `start`, then bytes 03 00 A5 01 03 00 00 01 back-to-back.
  - Response: writes addr0=0x1A5, addr1=0x003, addr2=0x100, each one cycle after its high byte. `load_done`=1 and `cpu_hold`=0 two cycles after the final byte.
- Stalled stream:
  - Stimulus: same bytes as above, with `in_valid` low for 3 cycles between every byte.
  - Response: identical writes and no extra `imem_wr_en` pulses.
- Bad word: bytes 02 00 11 00 22 02 → one write (addr0=0x011). Second word not written. `err`=1, `cpu_hold`=1, `in_ready`=0.
- Zero count: bytes 00 00 → no writes. `load_done`=1 two cycles after the second byte.
- Abort and restart:
  - Stimulus: reset low for 1 cycle after byte 3 of the basic stream, then `start` and the full stream. Separately, `start` pulsed mid-stream.
  - Response: in both cases, outputs return to the reset values or HDR_LO respectively, and the following full stream completes correctly from addr0.
- Checksum (macro on):
  - Stimulus: 01 00 5A 01 5A (matching XOR), then a repeat with a trailing 00.
  - Response: the first gives write addr0=0x15A and `load_done`=1. The second gives `err`=1 with the write still performed.
